wave_seq_ctrl: RTL and testbench

Segment sequencer for the triangular-wave generator. It holds a small programmable table of (amplitude, prescaler, duration) segments and plays them in order. For each segment it drives the generator's enable, amplitude and prescaler inputs. Between segments it forces a one-cycle enable-low gap, so the generator restarts from zero before a new amplitude applies; this prevents runaway when the new amplitude is below the current sample. The block sits between the configuration register interface and the waveform generator.

---
 rtl/wave_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_wave_seq_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wave_seq_ctrl.sv
// Segment sequencer for the triangular-wave generator: plays (amp, psc, dur) table entries with a one-cycle enable-low gap between segments.
// Latency: start/stop take effect one cycle after sampling; no backpressure, table writes accepted every cycle.
module wave_seq_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [15:0]   cfg_amp,
    input  logic [15:0]   cfg_psc,
    input  logic [15:0]   cfg_dur,
    input  logic [AW-1:0] last_seg,
    input  logic          loop,
    input  logic          start,
    input  logic          stop,
    output logic          gen_ena,
    output logic [15:0]   gen_amplitude,
    output logic [15:0]   gen_prescaler,
    output logic [AW-1:0] seg_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   cnt;
    logic [15:0]   cnt_nxt;
    logic [15:0]   dur;
    logic [15:0]   dur_nxt;
    logic [15:0]   amp_nxt;
    logic [15:0]   psc_nxt;
    logic [AW-1:0] idx_nxt;
    logic [AW-1:0] last_r;
    logic [AW-1:0] last_nxt;
    logic          loop_r;
    logic          loop_nxt;
    logic          ena_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic          load;
    logic [AW-1:0] load_idx;
    logic [47:0]   entry;

    // Table layout per entry: {amp, psc, dur}; survives reset on purpose.
    logic [47:0]   tbl [DEPTH];

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            tbl[cfg_addr] <= {cfg_amp, cfg_psc, cfg_dur};
        end
    end

    assign entry = tbl[load_idx];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dur_nxt   = dur;
        amp_nxt   = gen_amplitude;
        psc_nxt   = gen_prescaler;
        idx_nxt   = seg_idx;
        last_nxt  = last_r;
        loop_nxt  = loop_r;
        ena_nxt   = 1'b0;
        done_nxt  = 1'b0;
        load      = 1'b0;
        load_idx  = seg_idx;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    last_nxt  = last_seg;
                    loop_nxt  = loop;
                    load      = 1'b1;
                    load_idx  = '0;
                    ena_nxt   = 1'b1;
                end
            end
            RUN: begin
                ena_nxt = 1'b1;
                if (cnt == dur) begin
                    ena_nxt = 1'b0;
                    if (seg_idx != last_r) begin
                        state_nxt = GAP;
                        load      = 1'b1;
                        load_idx  = AW'(seg_idx + 1'b1);
                    end else if (loop_r) begin
                        state_nxt = GAP;
                        load      = 1'b1;
                        load_idx  = '0;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            GAP: begin
                state_nxt = RUN;
                ena_nxt   = 1'b1;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort wins over everything; outputs other than enable keep their last values.
        if (stop) begin
            state_nxt = IDLE;
            ena_nxt   = 1'b0;
            done_nxt  = 1'b0;
            load      = 1'b0;
            last_nxt  = last_r;
            loop_nxt  = loop_r;
        end

        if (load) begin
            amp_nxt = entry[47:32];
            psc_nxt = entry[31:16];
            dur_nxt = entry[15:0];
            cnt_nxt = '0;
            idx_nxt = load_idx;
        end

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            dur           <= '0;
            last_r        <= '0;
            loop_r        <= 1'b0;
            gen_ena       <= 1'b0;
            gen_amplitude <= '0;
            gen_prescaler <= '0;
            seg_idx       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            dur           <= dur_nxt;
            last_r        <= last_nxt;
            loop_r        <= loop_nxt;
            gen_ena       <= ena_nxt;
            gen_amplitude <= amp_nxt;
            gen_prescaler <= psc_nxt;
            seg_idx       <= idx_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
        end
    end

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Directed bench for wave_seq_ctrl: single segment, three segments, looping with live write and stop, reset mid-run.
module tb_wave_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_amp;
    logic [15:0] cfg_psc;
    logic [15:0] cfg_dur;
    logic [2:0]  last_seg;
    logic        loop;
    logic        start;
    logic        stop;
    logic        gen_ena;
    logic [15:0] gen_amplitude;
    logic [15:0] gen_prescaler;
    logic [2:0]  seg_idx;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    // Three-segment table {10,1,2},{3,0,0},{7,2,4}: expected per-cycle outputs.
    int e3 [11] = '{1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 1};
    int a3 [11] = '{10, 10, 10, 3, 3, 7, 7, 7, 7, 7, 7};
    int p3 [11] = '{1, 1, 1, 0, 0, 2, 2, 2, 2, 2, 2};
    int s3 [11] = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 2, 2};

    // Looping run; entry 1 amp rewritten to 99 while it plays (cycle 4), stop at cycle 19.
    int el [20] = '{1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 0, 1, 1};
    int al [20] = '{10, 10, 10, 3, 3, 7, 7, 7, 7, 7, 7, 10, 10, 10, 10, 99, 99, 7, 7, 7};
    int sl [20] = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 2, 2, 0, 0, 0, 0, 1, 1, 2, 2, 2};

    wave_seq_ctrl #(.DEPTH(8), .AW(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_amp       (cfg_amp),
        .cfg_psc       (cfg_psc),
        .cfg_dur       (cfg_dur),
        .last_seg      (last_seg),
        .loop          (loop),
        .start         (start),
        .stop          (stop),
        .gen_ena       (gen_ena),
        .gen_amplitude (gen_amplitude),
        .gen_prescaler (gen_prescaler),
        .seg_idx       (seg_idx),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] amp, input logic [15:0] psc,
                      input logic [15:0] dur);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_amp  = amp;
        cfg_psc  = psc;
        cfg_dur  = dur;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ena"},  32'(gen_ena), 0);
        check({tag, "_amp"},  32'(gen_amplitude), 0);
        check({tag, "_psc"},  32'(gen_prescaler), 0);
        check({tag, "_idx"},  32'(seg_idx), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_amp = '0; cfg_psc = '0; cfg_dur = '0;
        last_seg = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
        tick();
        tick();
        check_reset_vals("por");
        rst = 1'b0;

        // Single segment
        wr(3'd0, 16'd5, 16'd0, 16'd3);
        last_seg = 3'd0; loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("single_ena_%0d", i), 32'(gen_ena), 1);
            check($sformatf("single_amp_%0d", i), 32'(gen_amplitude), 5);
            check($sformatf("single_busy_%0d", i), 32'(busy), 1);
            tick();
        end
        check("single_done", 32'(done), 1);
        check("single_done_ena", 32'(gen_ena), 0);
        check("single_done_busy", 32'(busy), 0);
        check("single_amp_held", 32'(gen_amplitude), 5);
        tick();
        check("single_done_pulse", 32'(done), 0);

        // Three segments; last_seg/loop changed after start must be ignored, as must a start while busy
        wr(3'd0, 16'd10, 16'd1, 16'd2);
        wr(3'd1, 16'd3, 16'd0, 16'd0);
        wr(3'd2, 16'd7, 16'd2, 16'd4);
        last_seg = 3'd2; loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; last_seg = 3'd0; loop = 1'b1;
        for (int i = 0; i < 11; i++) begin
            check($sformatf("seq3_ena_%0d", i), 32'(gen_ena), e3[i]);
            check($sformatf("seq3_amp_%0d", i), 32'(gen_amplitude), e3[i] >= 0 ? a3[i] : 0);
            check($sformatf("seq3_psc_%0d", i), 32'(gen_prescaler), p3[i]);
            check($sformatf("seq3_idx_%0d", i), 32'(seg_idx), s3[i]);
            check($sformatf("seq3_done_%0d", i), 32'(done), 0);
            start = (i == 1);
            tick();
        end
        start = 1'b0;
        check("seq3_done", 32'(done), 1);
        check("seq3_done_ena", 32'(gen_ena), 0);
        check("seq3_done_busy", 32'(busy), 0);
        check("seq3_done_idx", 32'(seg_idx), 2);
        loop = 1'b0;
        tick();

        // start and stop together from IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", 32'(busy), 0);
        check("startstop_ena", 32'(gen_ena), 0);
        tick();
        check("startstop_busy2", 32'(busy), 0);

        // Looping with live rewrite of entry 1, then stop mid-RUN
        last_seg = 3'd2; loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("loop_ena_%0d", i), 32'(gen_ena), el[i]);
            check($sformatf("loop_amp_%0d", i), 32'(gen_amplitude), al[i]);
            check($sformatf("loop_idx_%0d", i), 32'(seg_idx), sl[i]);
            check($sformatf("loop_busy_%0d", i), 32'(busy), 1);
            cfg_we   = (i == 4);
            cfg_addr = 3'd1;
            cfg_amp  = 16'd99;
            cfg_psc  = 16'd0;
            cfg_dur  = 16'd0;
            stop     = (i == 19);
            tick();
        end
        cfg_we = 1'b0; stop = 1'b0;
        check("stop_ena", 32'(gen_ena), 0);
        check("stop_busy", 32'(busy), 0);
        check("stop_done", 32'(done), 0);
        check("stop_amp_held", 32'(gen_amplitude), 7);
        check("stop_psc_held", 32'(gen_prescaler), 2);
        check("stop_idx_held", 32'(seg_idx), 2);
        tick();
        check("stop_done2", 32'(done), 0);
        check("stop_busy2", 32'(busy), 0);

        // Reset mid-playback, table retained
        loop = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_reset_vals("rst1");
        tick();
        check_reset_vals("rst2");
        rst = 1'b0;
        tick();
        check("rst_idle_busy", 32'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rerun_ena", 32'(gen_ena), 1);
        check("rerun_amp", 32'(gen_amplitude), 10);
        check("rerun_psc", 32'(gen_prescaler), 1);
        tick();
        tick();
        tick();
        check("rerun_gap_ena", 32'(gen_ena), 0);
        check("rerun_gap_amp", 32'(gen_amplitude), 99);
        check("rerun_gap_idx", 32'(seg_idx), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
